// File: rtl/bc_operand_source_pkg.sv
// Shared types for the broadcast-chain operand source: element word and FSM states.
// Types only; no logic, no latency, no flow control.
package bc_operand_source_pkg;

    typedef logic [63:0] elen_t;

    typedef enum logic [1:0] {
        BC_SRC_IDLE,
        BC_SRC_SEND,
        BC_SRC_DRAIN
    } bc_src_state_e;

endpackage

// File: rtl/bc_credit_counter.sv
// In-flight word counter for the broadcast ring; saturates at both ends.
// Latency: avail/zero/one are registered, so a return frees its credit the next cycle.
// Backpressure: inc ignored at MaxInflight, dec ignored at zero.
module bc_credit_counter #(
    parameter int unsigned MaxInflight = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic avail_o,
    output logic zero_o,
    output logic one_o
);
    localparam int unsigned CntWidth = $clog2(MaxInflight + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxInflight);

    logic [CntWidth-1:0] cnt_q;
    logic inc, dec;

    assign avail_o = (cnt_q < CntMax);
    assign zero_o  = (cnt_q == '0);
    assign one_o   = (cnt_q == CntWidth'(1));
    assign inc     = inc_i && avail_o;
    assign dec     = dec_i && !zero_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (inc && !dec) begin
            cnt_q <= cnt_q + 1'b1;
        end else if (dec && !inc) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/fifo_v3.sv
// Generic synchronous FIFO; only compiled when BC_SOURCE_RET_CHECK_EN is defined.
// Latency: data_o shows the head entry combinationally, one cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty.
`ifdef BC_SOURCE_RET_CHECK_EN
module fifo_v3 #(
    parameter int unsigned Depth = 4,
    parameter type dtype = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic pop_i,
    input  dtype data_i,
    output dtype data_o,
    output logic full_o,
    output logic empty_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    dtype mem_q [Depth];
    logic [PtrW-1:0] rd_q, wr_q;
    logic [PtrW:0] cnt_q;
    logic do_push, do_pop;

    assign full_o  = (cnt_q == (PtrW + 1)'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= (wr_q == LastPtr) ? '0 : wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= (rd_q == LastPtr) ? '0 : rd_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/bc_operand_source.sv
// Broadcast-ring head: injects operands into lane 0, counts returns, pulses done per command. Macro: BC_SOURCE_RET_CHECK_EN.
// Latency: operand->lane 0 is combinational; done is registered one cycle after the last return.
// Backpressure: op_ready follows bc_ready gated by credits; returns are always accepted.
module bc_operand_source
    import bc_operand_source_pkg::*;
#(
    parameter int unsigned MaxInflight = 4,
    parameter int unsigned LenWidth    = 16,
    parameter int unsigned IdWidth     = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [LenWidth-1:0] cmd_len_i,
    input  logic [IdWidth-1:0]  cmd_id_i,
    input  logic                op_valid_i,
    output logic                op_ready_o,
    input  elen_t               op_data_i,
    output logic                bc_valid_o,
    input  logic                bc_ready_i,
    output elen_t               bc_data_o,
    input  logic                ret_valid_i,
    output logic                ret_ready_o,
    input  elen_t               ret_data_i,
    output logic                done_valid_o,
    output logic [IdWidth-1:0]  done_id_o,
    output logic                busy_o,
    output logic                err_o
);
    bc_src_state_e state_q, state_d;
    logic [LenWidth-1:0] remaining_q;
    logic [IdWidth-1:0]  id_q, done_id_q;
    logic done_valid_q, err_q;
    logic avail, zero, one, send, ret_take, done_set, ret_mismatch;

    // A return with nothing in flight is spurious: it must not touch the counter.
    assign ret_take = ret_valid_i && !zero;

    bc_credit_counter #(.MaxInflight(MaxInflight)) i_credit (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (send),
        .dec_i   (ret_take),
        .avail_o (avail),
        .zero_o  (zero),
        .one_o   (one)
    );

`ifdef BC_SOURCE_RET_CHECK_EN
    elen_t exp_ret;
    logic  unused_fifo_full, unused_fifo_empty;

    fifo_v3 #(.Depth(MaxInflight), .dtype(elen_t)) i_check_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (send),
        .pop_i   (ret_take),
        .data_i  (op_data_i),
        .data_o  (exp_ret),
        .full_o  (unused_fifo_full),
        .empty_o (unused_fifo_empty)
    );
    assign ret_mismatch = ret_take && (exp_ret != ret_data_i);
`else
    logic unused_ret_data;
    assign unused_ret_data = ^ret_data_i;
    assign ret_mismatch    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        op_ready_o  = 1'b0;
        bc_valid_o  = 1'b0;
        bc_data_o   = '0;
        send        = 1'b0;
        done_set    = 1'b0;
        unique case (state_q)
            BC_SRC_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    if (cmd_len_i != '0) state_d = BC_SRC_SEND;
                    else                 done_set = 1'b1;
                end
            end
            BC_SRC_SEND: begin
                bc_valid_o = op_valid_i && avail;
                op_ready_o = bc_ready_i && avail;
                if (bc_valid_o) bc_data_o = op_data_i;
                send = bc_valid_o && bc_ready_i;
                if (send && remaining_q == LenWidth'(1)) state_d = BC_SRC_DRAIN;
            end
            BC_SRC_DRAIN: begin
                if (zero || (one && ret_valid_i)) begin
                    done_set = 1'b1;
                    state_d  = BC_SRC_IDLE;
                end
            end
            default: state_d = BC_SRC_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= BC_SRC_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            remaining_q  <= '0;
            id_q         <= '0;
            done_valid_q <= 1'b0;
            done_id_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            done_valid_q <= done_set;
            if (done_set) begin
                done_id_q <= (state_q == BC_SRC_IDLE) ? cmd_id_i : id_q;
            end
            if (state_q == BC_SRC_IDLE && cmd_valid_i) begin
                remaining_q <= cmd_len_i;
                id_q        <= cmd_id_i;
            end else if (send) begin
                remaining_q <= remaining_q - 1'b1;
            end
            if ((ret_valid_i && zero) || ret_mismatch) begin
                err_q <= 1'b1;
            end
        end
    end

    assign ret_ready_o  = 1'b1;
    assign done_valid_o = done_valid_q;
    assign done_id_o    = done_id_q;
    assign busy_o       = (state_q != BC_SRC_IDLE);
    assign err_o        = err_q;

endmodule
